// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/done handshake bundle for the bit-serial adder
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  modport master (
    output start_valid, A, B, Cin, done_ready,
    input  start_ready, Sum, Cout, done_valid, busy
  );

  modport slave (
    input  start_valid, A, B, Cin, done_ready,
    output start_ready, Sum, Cout, done_valid, busy
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder driving a single full_adder cell
// One operand bit per clock; the carry is registered and fed back into the cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             start_ready_q;
  logic             done_valid_q;
  logic             busy_q;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  full_adder u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_sh_d = fa_s;
    end else begin : g_wn
      assign sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      a_sh_q        <= '0;
      b_sh_q        <= '0;
      sum_sh_q      <= '0;
      sum_q         <= '0;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      cout_q        <= 1'b0;
      start_ready_q <= 1'b1;
      done_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_valid) begin
            a_sh_q        <= bus.A;
            b_sh_q        <= bus.B;
            carry_q       <= bus.Cin;
            sum_sh_q      <= '0;
            cnt_q         <= '0;
            state_q       <= S_RUN;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_c;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit) begin
            sum_q        <= sum_sh_d;
            cout_q       <= fa_c;
            state_q      <= S_DONE;
            done_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.done_ready) begin
            state_q       <= S_IDLE;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          done_valid_q  <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.busy        = busy_q;
  assign bus.Sum         = sum_q;
  assign bus.Cout        = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random checks of serial_adder at WIDTH 4, 1 and 16
module tb_serial_adder;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_adder_if #(.WIDTH(4))  ifc4  ();
  serial_adder_if #(.WIDTH(1))  ifc1  ();
  serial_adder_if #(.WIDTH(16)) ifc16 ();

  serial_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(ifc4.slave));
  serial_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));
  serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(ifc16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    ifc4.A = a;
    ifc4.B = b;
    ifc4.Cin = cin;
    ifc4.start_valid = 1'b1;
    @(negedge clk);
    ifc4.start_valid = 1'b0;
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    while (!ifc4.done_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic ack4();
    ifc4.done_ready = 1'b1;
    @(negedge clk);
    ifc4.done_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (ifc4.start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b want 1", ifc4.start_ready); end
    checks++; if (ifc4.done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid: got %b want 0", ifc4.done_valid); end
    checks++; if (ifc4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ifc4.busy); end
    checks++; if (ifc4.Sum !== 4'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", ifc4.Sum); end
    checks++; if (ifc4.Cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", ifc4.Cout); end
  endtask

  task automatic test_basic();
    int n;
    start4(4'h5, 4'h3, 1'b0);
    checks++; if (ifc4.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_run: got %b want 1", ifc4.busy); end
    wait_done4(n);
    checks++; if (n != 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", n); end
    checks++; if (ifc4.Sum !== 4'h8) begin errors++; $display("FAIL basic_sum: got %h want 8", ifc4.Sum); end
    checks++; if (ifc4.Cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b want 0", ifc4.Cout); end
    checks++; if (ifc4.start_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done: got %b want 0", ifc4.start_ready); end
    ack4();
    checks++; if (ifc4.start_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %b want 1", ifc4.start_ready); end
    checks++; if (ifc4.done_valid !== 1'b0) begin errors++; $display("FAIL basic_dv_idle: got %b want 0", ifc4.done_valid); end
    checks++; if (ifc4.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b want 0", ifc4.busy); end
  endtask

  task automatic test_vectors();
    logic [3:0] va [3] = '{4'hF, 4'hF, 4'h0};
    logic [3:0] vb [3] = '{4'h1, 4'hF, 4'h0};
    logic       vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] es [3] = '{4'h0, 4'hF, 4'h1};
    logic       ec [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] prev;
    int n;
    prev = 4'h8;
    for (int i = 0; i < 3; i++) begin
      start4(va[i], vb[i], vc[i]);
      checks++; if (ifc4.Sum !== prev) begin errors++; $display("FAIL vec%0d_sum_hold: got %h want %h", i, ifc4.Sum, prev); end
      wait_done4(n);
      checks++; if (n != 4) begin errors++; $display("FAIL vec%0d_latency: got %0d want 4", i, n); end
      checks++; if (ifc4.Sum !== es[i]) begin errors++; $display("FAIL vec%0d_sum: got %h want %h", i, ifc4.Sum, es[i]); end
      checks++; if (ifc4.Cout !== ec[i]) begin errors++; $display("FAIL vec%0d_cout: got %b want %b", i, ifc4.Cout, ec[i]); end
      ack4();
      prev = es[i];
    end
  endtask

  task automatic test_backpressure();
    int n;
    start4(4'hC, 4'h5, 1'b1);
    wait_done4(n);
    checks++; if (n != 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", n); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (ifc4.done_valid !== 1'b1) begin errors++; $display("FAIL bp_dv_%0d: got %b want 1", i, ifc4.done_valid); end
      checks++; if (ifc4.Sum !== 4'h2) begin errors++; $display("FAIL bp_sum_%0d: got %h want 2", i, ifc4.Sum); end
      checks++; if (ifc4.Cout !== 1'b1) begin errors++; $display("FAIL bp_cout_%0d: got %b want 1", i, ifc4.Cout); end
      checks++; if (ifc4.start_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b want 0", i, ifc4.start_ready); end
    end
    ack4();
    checks++; if (ifc4.done_valid !== 1'b0) begin errors++; $display("FAIL bp_dv_release: got %b want 0", ifc4.done_valid); end
    checks++; if (ifc4.start_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b want 1", ifc4.start_ready); end
  endtask

  task automatic test_operand_hold();
    int n;
    ifc4.A = 4'h9;
    ifc4.B = 4'h6;
    ifc4.Cin = 1'b0;
    ifc4.start_valid = 1'b1;
    @(negedge clk);
    ifc4.A = 4'hF;
    ifc4.B = 4'hF;
    checks++; if (ifc4.start_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_run: got %b want 0", ifc4.start_ready); end
    wait_done4(n);
    checks++; if (n != 4) begin errors++; $display("FAIL hold_latency: got %0d want 4", n); end
    checks++; if (ifc4.Sum !== 4'hF) begin errors++; $display("FAIL hold_sum: got %h want f", ifc4.Sum); end
    checks++; if (ifc4.Cout !== 1'b0) begin errors++; $display("FAIL hold_cout: got %b want 0", ifc4.Cout); end
    ack4();
    checks++; if (ifc4.start_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_idle: got %b want 1", ifc4.start_ready); end
    @(negedge clk);
    ifc4.start_valid = 1'b0;
    checks++; if (ifc4.busy !== 1'b1) begin errors++; $display("FAIL hold_second_accept: got busy=%b want 1", ifc4.busy); end
    wait_done4(n);
    checks++; if (n != 4) begin errors++; $display("FAIL hold2_latency: got %0d want 4", n); end
    checks++; if (ifc4.Sum !== 4'hE) begin errors++; $display("FAIL hold2_sum: got %h want e", ifc4.Sum); end
    checks++; if (ifc4.Cout !== 1'b1) begin errors++; $display("FAIL hold2_cout: got %b want 1", ifc4.Cout); end
    ack4();
  endtask

  task automatic test_reset_mid_run();
    int n;
    start4(4'h3, 4'hA, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ifc4.done_valid !== 1'b0) begin errors++; $display("FAIL rrun_dv: got %b want 0", ifc4.done_valid); end
    checks++; if (ifc4.Sum !== 4'h0) begin errors++; $display("FAIL rrun_sum: got %h want 0", ifc4.Sum); end
    checks++; if (ifc4.Cout !== 1'b0) begin errors++; $display("FAIL rrun_cout: got %b want 0", ifc4.Cout); end
    checks++; if (ifc4.busy !== 1'b0) begin errors++; $display("FAIL rrun_busy: got %b want 0", ifc4.busy); end
    checks++; if (ifc4.start_ready !== 1'b1) begin errors++; $display("FAIL rrun_ready: got %b want 1", ifc4.start_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ifc4.done_valid !== 1'b0) begin errors++; $display("FAIL rrun_no_stale: got %b want 0", ifc4.done_valid); end
    start4(4'h7, 4'h7, 1'b0);
    wait_done4(n);
    checks++; if (n != 4) begin errors++; $display("FAIL rrun_latency: got %0d want 4", n); end
    checks++; if (ifc4.Sum !== 4'hE) begin errors++; $display("FAIL rrun_sum_new: got %h want e", ifc4.Sum); end
    checks++; if (ifc4.Cout !== 1'b0) begin errors++; $display("FAIL rrun_cout_new: got %b want 0", ifc4.Cout); end
    ack4();
  endtask

  task automatic test_random_w4();
    logic [3:0] a, b;
    logic       c;
    logic [4:0] ref_sum;
    int n;
    for (int i = 0; i < 1000; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      c = 1'($urandom);
      ref_sum = {1'b0, a} + {1'b0, b} + {4'b0, c};
      start4(a, b, c);
      wait_done4(n);
      checks++; if (n != 4) begin errors++; $display("FAIL rnd4_latency: got %0d want 4", n); end
      checks++; if ({ifc4.Cout, ifc4.Sum} !== ref_sum) begin errors++; $display("FAIL rnd4_result %h+%h+%b: got %h want %h", a, b, c, {ifc4.Cout, ifc4.Sum}, ref_sum); end
      ack4();
    end
  endtask

  task automatic test_random_w1();
    logic a, b, c;
    logic [1:0] ref_sum;
    int n;
    for (int i = 0; i < 1000; i++) begin
      a = 1'($urandom);
      b = 1'($urandom);
      c = 1'($urandom);
      ref_sum = {1'b0, a} + {1'b0, b} + {1'b0, c};
      ifc1.A = a;
      ifc1.B = b;
      ifc1.Cin = c;
      ifc1.start_valid = 1'b1;
      @(negedge clk);
      ifc1.start_valid = 1'b0;
      n = 0;
      while (!ifc1.done_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++; if (n != 1) begin errors++; $display("FAIL rnd1_latency: got %0d want 1", n); end
      checks++; if ({ifc1.Cout, ifc1.Sum} !== ref_sum) begin errors++; $display("FAIL rnd1_result %b+%b+%b: got %b want %b", a, b, c, {ifc1.Cout, ifc1.Sum}, ref_sum); end
      ifc1.done_ready = 1'b1;
      @(negedge clk);
      ifc1.done_ready = 1'b0;
    end
  endtask

  task automatic test_random_w16();
    logic [15:0] a, b;
    logic        c;
    logic [16:0] ref_sum;
    int n;
    for (int i = 0; i < 200; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      if (i == 0) begin a = 16'hFFFF; b = 16'h0000; c = 1'b1; end
      ref_sum = {1'b0, a} + {1'b0, b} + {16'b0, c};
      ifc16.A = a;
      ifc16.B = b;
      ifc16.Cin = c;
      ifc16.start_valid = 1'b1;
      @(negedge clk);
      ifc16.start_valid = 1'b0;
      n = 0;
      while (!ifc16.done_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++; if (n != 16) begin errors++; $display("FAIL rnd16_latency: got %0d want 16", n); end
      checks++; if ({ifc16.Cout, ifc16.Sum} !== ref_sum) begin errors++; $display("FAIL rnd16_result %h+%h+%b: got %h want %h", a, b, c, {ifc16.Cout, ifc16.Sum}, ref_sum); end
      ifc16.done_ready = 1'b1;
      @(negedge clk);
      ifc16.done_ready = 1'b0;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    ifc4.start_valid = 1'b0;  ifc4.A = '0;  ifc4.B = '0;  ifc4.Cin = 1'b0;  ifc4.done_ready = 1'b0;
    ifc1.start_valid = 1'b0;  ifc1.A = '0;  ifc1.B = '0;  ifc1.Cin = 1'b0;  ifc1.done_ready = 1'b0;
    ifc16.start_valid = 1'b0; ifc16.A = '0; ifc16.B = '0; ifc16.Cin = 1'b0; ifc16.done_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_operand_hold();
    test_reset_mid_run();
    test_random_w4();
    test_random_w1();
    test_random_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder built around one instance of the team's single-bit full_adder cell. This block is the sequential stage that drives that cell.
- It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- It adds them LSB-first, one bit per clock, through the full_adder, with a registered carry fed back to Cin.
- It returns the WIDTH-bit sum and carry-out through a second valid/ready handshake.
- It is the area-minimal alternative to the ripple-carry four-bit adder in the arithmetic_circuits library.

Parameters:
WIDTH, 4, operand/sum width in bits; legal range 1..64.

Ports:
clk  input  1  single clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operands A, B, Cin valid
start_ready  output  1  block can accept operands
A  input  WIDTH  operand A, sampled on start handshake
B  input  WIDTH  operand B, sampled on start handshake
Cin  input  1  carry-in, sampled on start handshake
Sum  output  WIDTH  result sum (A+B+Cin) mod 2^WIDTH
Cout  output  1  result carry-out (bit WIDTH of A+B+Cin)
done_valid  output  1  Sum/Cout hold a new result
done_ready  input  1  consumer accepts result
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low. Assertion immediately forces the reset state regardless of clk. Deassertion is synchronised externally.
- Reset values:
  - state=IDLE, start_ready=1, done_valid=0, busy=0.
  - Sum=0, Cout=0.
  - Operand shift registers, carry register and bit counter all 0.
- FSM states:
  - IDLE: start_ready=1. On start_valid&&start_ready at a rising edge: capture A, B into shift regs, load carry reg with Cin, clear counter, go to RUN. No handshake means stay in IDLE.
  - RUN: start_ready=0, busy=1. Each edge:
    - full_adder computes A_sh[0]+B_sh[0]+carry.
    - The sum bit shifts into the MSB of the sum shift reg (shift right).
    - A_sh and B_sh shift right by one.
    - carry <= full_adder Cout.
    - counter increments.
    - On the edge where counter==WIDTH-1 (the last bit): copy the completed sum to Sum, copy the final carry to Cout, go to DONE.
  - DONE: done_valid=1, start_ready=0, busy=1. Sum/Cout are stable. On done_valid&&done_ready at an edge, go to IDLE and drop done_valid. Otherwise hold indefinitely (backpressure).
- Latency: start accepted at edge 0 → done_valid high in the cycle after edge WIDTH (exactly WIDTH cycles). Minimum issue interval is WIDTH+2 cycles (RUN WIDTH, DONE ≥1, IDLE ≥1). There is no DONE→RUN bypass.
- Output stability:
  - Sum and Cout change only on the RUN→DONE edge. They hold the last result through IDLE and RUN of the next operation.
  - A, B, Cin inputs are ignored outside the IDLE handshake edge. Changing them during RUN has no effect.
- Arithmetic: unsigned modulo 2^WIDTH, with Cout = overflow bit. Results must equal A+B+Cin computed as WIDTH+1 bits.
- WIDTH=1: RUN lasts exactly one cycle.
- Counter width is clog2(WIDTH+1). It must never wrap within one operation.
- start_valid in RUN or DONE is not accepted (start_ready=0). The upstream must hold it.
- done_ready asserted outside DONE has no effect.
- Reset mid-RUN or mid-DONE: the operation is aborted with no partial result. All outputs return to reset values asynchronously. The next result is produced only after a fresh start handshake.

Test Plan:
1. Reset, then start A=4'h5, B=4'h3, Cin=0, done_ready=1 → done_valid rises exactly 4 cycles after the handshake; Sum=4'h8, Cout=0; start_ready=1 two cycles after the handshake into DONE... specifically, start_ready returns high the cycle after the done handshake.
2. A=4'hF, B=4'h1, Cin=0 → Sum=4'h0, Cout=1. Then A=4'hF, B=4'hF, Cin=1 → Sum=4'hF, Cout=1. Then A=0, B=0, Cin=1 → Sum=4'h1, Cout=0.
3. Backpressure: done_ready=0 for 10 cycles after done_valid → done_valid, Sum, Cout stay constant and start_ready stays 0. Raising done_ready → one handshake, then IDLE.
4. Operand hold: start A=4'h9, B=4'h6, Cin=0, then drive A=4'hF, B=4'hF with start_valid=1 during RUN → no second capture; Sum=4'hF, Cout=0. The held start is accepted only after returning to IDLE.
5. Reset asserted 2 cycles into RUN → done_valid, Sum, Cout and busy go to 0 immediately and start_ready goes to 1. A new start of 4'h7+4'h7 yields Sum=4'hE, Cout=0.
6. Random regression: 1000 random operands with WIDTH=4 and WIDTH=1, plus 200 with WIDTH=16, against a WIDTH+1-bit reference sum → all match, and latency is always WIDTH cycles.
